ite_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one WIDTH-bit select/mux datapath between NREQ requesters, each using a valid/ready handshake.
- Each cycle it picks one valid requester, steers that requester's data through the mux and registers the result into a single-entry output slot.
- The slot has its own valid/ready handshake.
- Sits in front of any shared Bits datapath consumer. Replaces ad-hoc ite select chains wherever more than one producer drives one bus.

---
 rtl/ite_rr_arbiter_if.sv | 22 ++
 rtl/ite_rr_arbiter.sv | 85 ++++++++
 tb/tb_ite_rr_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ite_rr_arbiter_if.sv
// ite_rr_arbiter_if: requester and output-slot handshake bundle; I_lock exists only with ITE_ARB_LOCK_EN.
interface ite_rr_arbiter_if #(
    parameter int WIDTH = 3,
    parameter int NREQ = 4
);
    localparam int GW = $clog2(NREQ);
    logic [NREQ-1:0] I_valid;
    logic [NREQ*WIDTH-1:0] I_data;
    logic [NREQ-1:0] I_ready;
    logic O_valid;
    logic [WIDTH-1:0] O_data;
    logic [GW-1:0] O_grant;
    logic O_ready;
`ifdef ITE_ARB_LOCK_EN
    logic [NREQ-1:0] I_lock;
    modport master (output I_valid, I_data, I_lock, O_ready, input I_ready, O_valid, O_data, O_grant);
    modport slave (input I_valid, I_data, I_lock, O_ready, output I_ready, O_valid, O_data, O_grant);
`else
    modport master (output I_valid, I_data, O_ready, input I_ready, O_valid, O_data, O_grant);
    modport slave (input I_valid, I_data, O_ready, output I_ready, O_valid, O_data, O_grant);
`endif
endinterface

// File: rtl/ite_rr_arbiter.sv
// ite_rr_arbiter: round-robin valid/ready arbiter into a one-entry output slot; ITE_ARB_LOCK_EN adds packet lock.
module ite_rr_arbiter #(
    parameter int WIDTH = 3,
    parameter int NREQ = 4,
    localparam int GW = $clog2(NREQ)
) (
    input logic CLK,
    input logic RESET,
    ite_rr_arbiter_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_e;
    state_e state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [GW-1:0] grant_q, grant_d, ptr_q, ptr_d, win;
    logic [GW:0] idx;
    logic found, load;
`ifdef ITE_ARB_LOCK_EN
    logic lock_q, lock_d;
`endif
    assign load = !RESET && (state_q == EMPTY || bus.O_ready);
    assign bus.I_ready = (load && found) ? NREQ'(1) << win : '0;
    assign bus.O_valid = state_q == FULL;
    assign bus.O_data = data_q;
    assign bus.O_grant = grant_q;
    always_comb begin
        found = 1'b0;
        win = '0;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr_q} + (GW+1)'(k);
            idx = (idx >= (GW+1)'(NREQ)) ? idx - (GW+1)'(NREQ) : idx;
            if (!found && bus.I_valid[idx[GW-1:0]]) begin
                found = 1'b1;
                win = idx[GW-1:0];
            end
        end
`ifdef ITE_ARB_LOCK_EN
        // a locked packet owns the datapath until its final beat
        if (lock_q) begin
            found = bus.I_valid[ptr_q];
            win = ptr_q;
        end
`endif
    end
    always_comb begin
        state_d = state_q;
        data_d = data_q;
        grant_d = grant_q;
        ptr_d = ptr_q;
`ifdef ITE_ARB_LOCK_EN
        lock_d = lock_q;
`endif
        if (load) begin
            state_d = found ? FULL : EMPTY;
            if (found) begin
                data_d = bus.I_data[win*WIDTH +: WIDTH];
                grant_d = win;
                ptr_d = (win == GW'(NREQ-1)) ? '0 : win + 1'b1;
`ifdef ITE_ARB_LOCK_EN
                ptr_d = bus.I_lock[win] ? win : ptr_d;
                lock_d = bus.I_lock[win];
`endif
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= EMPTY;
            data_q <= '0;
            grant_q <= '0;
            ptr_q <= '0;
`ifdef ITE_ARB_LOCK_EN
            lock_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q <= data_d;
            grant_q <= grant_d;
            ptr_q <= ptr_d;
`ifdef ITE_ARB_LOCK_EN
            lock_q <= lock_d;
`endif
        end
    end
endmodule

// File: tb/tb_ite_rr_arbiter.sv
// tb_ite_rr_arbiter: vector table, directed wrap/lock sequences and a randomized reference-model run.
module tb_ite_rr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst3 = 1'b1;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;

    ite_rr_arbiter_if #(.WIDTH(3), .NREQ(4)) b4();
    ite_rr_arbiter_if #(.WIDTH(3), .NREQ(3)) b3();
    ite_rr_arbiter #(.WIDTH(3), .NREQ(4)) u4(.CLK(clk), .RESET(rst), .bus(b4.slave));
    ite_rr_arbiter #(.WIDTH(3), .NREQ(3)) u3(.CLK(clk), .RESET(rst3), .bus(b3.slave));

    typedef struct {
        logic rst;
        logic [3:0] v;
        logic [11:0] d;
        logic r;
        logic [3:0] ir;
        logic ov;
        logic [2:0] od;
        logic [1:0] og;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step3(input logic [2:0] v, input logic [2:0] exp_ir, input logic [1:0] exp_g);
        @(negedge clk);
        rst3 = 1'b0;
        b3.I_valid = v;
        #1 chk("n3_ready", 32'(b3.I_ready), 32'(exp_ir));
        @(posedge clk);
        #1 chk("n3_grant", 32'(b3.O_grant), 32'(exp_g));
        chk("n3_valid", 32'(b3.O_valid), 32'd1);
    endtask

`ifdef ITE_ARB_LOCK_EN
    task automatic step_l(input logic [3:0] v, input logic [3:0] lk, input logic [3:0] exp_ir,
                          input logic exp_ov, input logic [1:0] exp_g);
        @(negedge clk);
        rst = 1'b0;
        b4.I_valid = v;
        b4.I_lock = lk;
        #1 chk("lock_ready", 32'(b4.I_ready), 32'(exp_ir));
        @(posedge clk);
        #1 chk("lock_valid", 32'(b4.O_valid), 32'(exp_ov));
        chk("lock_grant", 32'(b4.O_grant), 32'(exp_g));
    endtask
`endif

    logic m_v;
    int m_d, m_g, m_p, w, k_i;
    logic r_rst, r_rdy, m_load;
    logic [3:0] r_v, e_ir;
    logic [11:0] r_d;

    initial begin
        b4.I_valid = 4'hF;
        b4.I_data = 12'h8D1;
        b4.O_ready = 1'b1;
        b3.I_valid = '0;
        b3.I_data = 9'h0D1;
        b3.O_ready = 1'b1;
`ifdef ITE_ARB_LOCK_EN
        b4.I_lock = '0;
        b3.I_lock = '0;
`endif
        tbl[0]  = '{1'b1, 4'hF, 12'h8D1, 1'b1, 4'b0000, 1'b0, 3'd0, 2'd0};
        tbl[1]  = '{1'b1, 4'hF, 12'h8D1, 1'b1, 4'b0000, 1'b0, 3'd0, 2'd0};
        tbl[2]  = '{1'b0, 4'hF, 12'h8D1, 1'b1, 4'b0001, 1'b0, 3'd0, 2'd0};
        tbl[3]  = '{1'b0, 4'b0100, 12'h140, 1'b1, 4'b0100, 1'b1, 3'd1, 2'd0};
        tbl[4]  = '{1'b0, 4'b0000, 12'h140, 1'b1, 4'b0000, 1'b1, 3'd5, 2'd2};
        tbl[5]  = '{1'b1, 4'hF, 12'h8D1, 1'b1, 4'b0000, 1'b0, 3'd5, 2'd2};
        tbl[6]  = '{1'b0, 4'hF, 12'h8D1, 1'b1, 4'b0001, 1'b0, 3'd0, 2'd0};
        tbl[7]  = '{1'b0, 4'hF, 12'h8D1, 1'b1, 4'b0010, 1'b1, 3'd1, 2'd0};
        tbl[8]  = '{1'b0, 4'hF, 12'h8D1, 1'b1, 4'b0100, 1'b1, 3'd2, 2'd1};
        tbl[9]  = '{1'b0, 4'hF, 12'h8D1, 1'b1, 4'b1000, 1'b1, 3'd3, 2'd2};
        tbl[10] = '{1'b0, 4'hF, 12'h8D1, 1'b1, 4'b0001, 1'b1, 3'd4, 2'd3};
        tbl[11] = '{1'b0, 4'hF, 12'h8D1, 1'b1, 4'b0010, 1'b1, 3'd1, 2'd0};
        tbl[12] = '{1'b0, 4'hF, 12'h8D1, 1'b0, 4'b0000, 1'b1, 3'd2, 2'd1};
        tbl[13] = '{1'b0, 4'hF, 12'h8D1, 1'b0, 4'b0000, 1'b1, 3'd2, 2'd1};
        tbl[14] = '{1'b0, 4'hF, 12'h8D1, 1'b0, 4'b0000, 1'b1, 3'd2, 2'd1};
        tbl[15] = '{1'b0, 4'hF, 12'h8D1, 1'b1, 4'b0100, 1'b1, 3'd2, 2'd1};
        tbl[16] = '{1'b0, 4'hF, 12'h8D1, 1'b1, 4'b1000, 1'b1, 3'd3, 2'd2};
        @(posedge clk);
        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst;
            b4.I_valid = tbl[i].v;
            b4.I_data = tbl[i].d;
            b4.O_ready = tbl[i].r;
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(b4.I_ready), 32'(tbl[i].ir));
            chk($sformatf("vec%0d_valid", i), 32'(b4.O_valid), 32'(tbl[i].ov));
            chk($sformatf("vec%0d_data", i), 32'(b4.O_data), 32'(tbl[i].od));
            chk($sformatf("vec%0d_grant", i), 32'(b4.O_grant), 32'(tbl[i].og));
        end

        // three requesters: wrap from 2 back to 0, then a lone requester 0 seen from ptr 2 and ptr 1
        @(negedge clk);
        rst3 = 1'b1;
        @(posedge clk);
        step3(3'b111, 3'b001, 2'd0);
        step3(3'b111, 3'b010, 2'd1);
        step3(3'b111, 3'b100, 2'd2);
        step3(3'b111, 3'b001, 2'd0);
        step3(3'b111, 3'b010, 2'd1);
        step3(3'b001, 3'b001, 2'd0);
        step3(3'b001, 3'b001, 2'd0);
        step3(3'b111, 3'b010, 2'd1);

`ifdef ITE_ARB_LOCK_EN
        @(negedge clk);
        rst = 1'b1;
        b4.O_ready = 1'b1;
        @(posedge clk);
        step_l(4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0);
        step_l(4'b1011, 4'b0010, 4'b0010, 1'b1, 2'd1);
        step_l(4'b1001, 4'b0000, 4'b0000, 1'b0, 2'd1);
        step_l(4'b1011, 4'b0010, 4'b0010, 1'b1, 2'd1);
        step_l(4'b1011, 4'b0000, 4'b0010, 1'b1, 2'd1);
        step_l(4'b1001, 4'b0000, 4'b1000, 1'b1, 2'd3);
        step_l(4'b1001, 4'b0000, 4'b0001, 1'b1, 2'd0);
        b4.I_lock = '0;
`endif

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        m_v = 1'b0;
        m_d = 0;
        m_g = 0;
        m_p = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            r_rst = ($urandom_range(0, 24) == 0);
            r_v = 4'($urandom);
            r_d = 12'($urandom);
            r_rdy = ($urandom_range(0, 3) != 0);
            rst = r_rst;
            b4.I_valid = r_v;
            b4.I_data = r_d;
            b4.O_ready = r_rdy;
            #1;
            m_load = !r_rst && (!m_v || r_rdy);
            w = -1;
            for (int k = 0; k < 4; k++) begin
                k_i = (m_p + k) % 4;
                if (m_load && w < 0 && r_v[k_i]) w = k_i;
            end
            e_ir = (w >= 0) ? 4'(1 << w) : 4'b0000;
            chk("rnd_ready", 32'(b4.I_ready), 32'(e_ir));
            chk("rnd_valid", 32'(b4.O_valid), 32'(m_v));
            chk("rnd_data", 32'(b4.O_data), 32'(m_d));
            chk("rnd_grant", 32'(b4.O_grant), 32'(m_g));
            if (r_rst) begin
                m_v = 1'b0;
                m_d = 0;
                m_g = 0;
                m_p = 0;
            end else if (m_load) begin
                m_v = (w >= 0);
                if (w >= 0) begin
                    m_d = int'((r_d >> (3 * w)) & 12'h7);
                    m_g = w;
                    m_p = (w + 1) % 4;
                end
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
